// File: rtl/idu.sv
// Decode stage: fetch->decode pipeline register with valid/ready handshake
// and a combinational RV32I (+csrrw/csrrs/ecall/mret/ebreak) decoder.
module idu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instF,
    input  logic [XLEN-1:0] pcF,
    input  logic [XLEN-1:0] snpcF,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [XLEN-1:0] instD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] snpcD,
    output logic            mvalidD,
    output logic            mwenD,
    output logic [7:0]      mwmaskD,
    output logic [2:0]      mrtypeD,
    output logic [2:0]      cmp_typeD,
    output logic            branchD,
    output logic            jumpD,
    output logic            jalrD,
    output logic [2:0]      ALU_opD,
    output logic [1:0]      ALUsrc1D,
    output logic [1:0]      ALUsrc2D,
    output logic [2:0]      rdregsrcD,
    output logic [2:0]      inst_type,
    output logic            ecallD,
    output logic            mretD,
    output logic            write_csr,
    output logic            stop_sim
);

    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3,
                           ALU_XOR = 3'd4, ALU_SLL = 3'd5, ALU_SRL = 3'd6, ALU_SRA = 3'd7;
    localparam logic [1:0] S1_RS1 = 2'd0, S1_PC = 2'd1, S1_ZERO = 2'd2;
    localparam logic [1:0] S2_RS2 = 2'd0, S2_IMM = 2'd1, S2_CSR = 2'd2, S2_ZERO = 2'd3;
    localparam logic [2:0] RD_ALU = 3'd0, RD_MEM = 3'd1, RD_SNPC = 3'd2, RD_CMP = 3'd3,
                           RD_CSR = 3'd4, RD_NONE = 3'd5;
    localparam logic [2:0] T_I = 3'd0, T_S = 3'd1, T_R = 3'd2, T_U = 3'd3, T_J = 3'd4, T_B = 3'd5;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL  = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BR   = 7'b1100011, OPC_LD   = 7'b0000011,
                           OPC_ST   = 7'b0100011, OPC_OPI  = 7'b0010011, OPC_OP   = 7'b0110011,
                           OPC_SYS  = 7'b1110011;

    // ---------------- pipeline register ----------------
    assign s_ready = ~m_valid | m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            instD   <= '0;
            pcD     <= '0;
            snpcD   <= '0;
        end else if (s_valid && s_ready) begin
            m_valid <= 1'b1;
            instD   <= instF;
            pcD     <= pcF;
            snpcD   <= snpcF;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // ---------------- decoder ----------------
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = instD[6:0];
    assign funct3 = instD[14:12];
    assign funct7 = instD[31:25];

    // OP and OP-IMM share one table; only OP checks funct7 on non-shift ops,
    // since for OP-IMM those bits are immediate.
    logic       ar_ok, ar_cmp, is_op, f7_zero, f7_alt;
    logic [2:0] ar_alu, ar_cmpt;
    assign is_op   = (opcode == OPC_OP);
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    always_comb begin
        ar_ok   = 1'b1;
        ar_cmp  = 1'b0;
        ar_alu  = ALU_ADD;
        ar_cmpt = 3'd0;
        case (funct3)
            3'b000: begin
                if (is_op && f7_alt)                ar_alu = ALU_SUB;
                else if (is_op && !f7_zero)         ar_ok  = 1'b0;
            end
            3'b001: begin ar_alu = ALU_SLL; ar_ok = f7_zero; end
            3'b010: begin ar_alu = ALU_SUB; ar_cmp = 1'b1; ar_cmpt = 3'd2; ar_ok = !is_op || f7_zero; end
            3'b011: begin ar_alu = ALU_SUB; ar_cmp = 1'b1; ar_cmpt = 3'd4; ar_ok = !is_op || f7_zero; end
            3'b100: begin ar_alu = ALU_XOR; ar_ok = !is_op || f7_zero; end
            3'b101: begin
                ar_alu = f7_alt ? ALU_SRA : ALU_SRL;
                ar_ok  = f7_zero || f7_alt;
            end
            3'b110: begin ar_alu = ALU_OR;  ar_ok = !is_op || f7_zero; end
            default: begin ar_alu = ALU_AND; ar_ok = !is_op || f7_zero; end
        endcase
    end

    always_comb begin
        mvalidD   = 1'b0;
        mwenD     = 1'b0;
        mwmaskD   = 8'h00;
        mrtypeD   = 3'd0;
        cmp_typeD = 3'd0;
        branchD   = 1'b0;
        jumpD     = 1'b0;
        jalrD     = 1'b0;
        ALU_opD   = ALU_ADD;
        ALUsrc1D  = S1_RS1;
        ALUsrc2D  = S2_RS2;
        rdregsrcD = RD_NONE;
        inst_type = T_I;
        ecallD    = 1'b0;
        mretD     = 1'b0;
        write_csr = 1'b0;
        stop_sim  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ALUsrc1D = S1_ZERO; ALUsrc2D = S2_IMM; inst_type = T_U; rdregsrcD = RD_ALU;
            end
            OPC_AUIPC: begin
                ALUsrc1D = S1_PC; ALUsrc2D = S2_IMM; inst_type = T_U; rdregsrcD = RD_ALU;
            end
            OPC_JAL: begin
                jumpD = 1'b1; inst_type = T_J; rdregsrcD = RD_SNPC;
            end
            OPC_JALR: if (funct3 == 3'b000) begin
                jumpD = 1'b1; jalrD = 1'b1; inst_type = T_I; rdregsrcD = RD_SNPC;
            end
            OPC_BR: if (funct3 != 3'b010 && funct3 != 3'b011) begin
                branchD = 1'b1; ALU_opD = ALU_SUB; inst_type = T_B;
                case (funct3)
                    3'b000:  cmp_typeD = 3'd0;
                    3'b001:  cmp_typeD = 3'd1;
                    3'b100:  cmp_typeD = 3'd2;
                    3'b101:  cmp_typeD = 3'd3;
                    3'b110:  cmp_typeD = 3'd4;
                    default: cmp_typeD = 3'd5;
                endcase
            end
            OPC_LD: if (funct3 != 3'b011 && funct3 < 3'b110) begin
                mvalidD = 1'b1; ALUsrc2D = S2_IMM; inst_type = T_I; rdregsrcD = RD_MEM;
                case (funct3)
                    3'b000:  mrtypeD = 3'd0;
                    3'b001:  mrtypeD = 3'd1;
                    3'b010:  mrtypeD = 3'd2;
                    3'b100:  mrtypeD = 3'd3;
                    default: mrtypeD = 3'd4;
                endcase
            end
            OPC_ST: if (funct3 <= 3'b010) begin
                mvalidD = 1'b1; mwenD = 1'b1; ALUsrc2D = S2_IMM; inst_type = T_S;
                case (funct3)
                    3'b000:  mwmaskD = 8'h01;
                    3'b001:  mwmaskD = 8'h03;
                    default: mwmaskD = 8'h0F;
                endcase
            end
            OPC_OPI, OPC_OP: if (ar_ok) begin
                ALU_opD   = ar_alu;
                cmp_typeD = ar_cmpt;
                ALUsrc2D  = is_op ? S2_RS2 : S2_IMM;
                inst_type = is_op ? T_R : T_I;
                rdregsrcD = ar_cmp ? RD_CMP : RD_ALU;
            end
            OPC_SYS: begin
                if (funct3 == 3'b001) begin
                    write_csr = 1'b1; ALUsrc2D = S2_ZERO; rdregsrcD = RD_CSR;
                end else if (funct3 == 3'b010) begin
                    write_csr = 1'b1; ALUsrc2D = S2_CSR; ALU_opD = ALU_OR; rdregsrcD = RD_CSR;
                end else if (instD == 32'h0000_0073) begin
                    ecallD = 1'b1;
                end else if (instD == 32'h3020_0073) begin
                    mretD = 1'b1;
                end else if (instD == 32'h0010_0073) begin
                    stop_sim = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_idu.sv
// Scoreboard bench for idu: stimulus pushes hand-computed expectations,
// a monitor pops and compares on every downstream transfer.
module tb_idu;

    typedef struct packed {
        logic       mvalid;
        logic       mwen;
        logic [7:0] mwmask;
        logic [2:0] mrtype;
        logic [2:0] cmpt;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [2:0] aluop;
        logic [1:0] src1;
        logic [1:0] src2;
        logic [2:0] rd;
        logic [2:0] itype;
        logic       ecall;
        logic       mret;
        logic       wcsr;
        logic       stop;
    } dec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] snpc;
        dec_t        dec;
    } item_t;

    logic        clk, rst;
    logic [31:0] instF, pcF, snpcF, instD, pcD, snpcD;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic        mvalidD, mwenD, branchD, jumpD, jalrD, ecallD, mretD, write_csr, stop_sim;
    logic [7:0]  mwmaskD;
    logic [2:0]  mrtypeD, cmp_typeD, ALU_opD, rdregsrcD, inst_type;
    logic [1:0]  ALUsrc1D, ALUsrc2D;
    dec_t        act;

    idu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .instF(instF), .pcF(pcF), .snpcF(snpcF),
        .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
        .instD(instD), .pcD(pcD), .snpcD(snpcD),
        .mvalidD(mvalidD), .mwenD(mwenD), .mwmaskD(mwmaskD), .mrtypeD(mrtypeD),
        .cmp_typeD(cmp_typeD), .branchD(branchD), .jumpD(jumpD), .jalrD(jalrD),
        .ALU_opD(ALU_opD), .ALUsrc1D(ALUsrc1D), .ALUsrc2D(ALUsrc2D),
        .rdregsrcD(rdregsrcD), .inst_type(inst_type),
        .ecallD(ecallD), .mretD(mretD), .write_csr(write_csr), .stop_sim(stop_sim)
    );

    assign act = {mvalidD, mwenD, mwmaskD, mrtypeD, cmp_typeD, branchD, jumpD, jalrD,
                  ALU_opD, ALUsrc1D, ALUsrc2D, rdregsrcD, inst_type,
                  ecallD, mretD, write_csr, stop_sim};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    item_t       q[$];
    logic [31:0] pc_n = 32'h8000_0000;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic dec_t dflt();
        dec_t d = '0;
        d.rd = 3'd5;
        return d;
    endfunction

    // Hand-computed decode for every instruction word used below.
    function automatic dec_t exp_dec(input logic [31:0] i);
        dec_t d = dflt();
        case (i)
            32'h0050_0093: begin d.src2 = 1; d.rd = 0; end                                   // addi
            32'hFE20_9EE3: begin d.branch = 1; d.cmpt = 1; d.aluop = 1; d.itype = 5; end      // bne
            32'h0020_F463: begin d.branch = 1; d.cmpt = 5; d.aluop = 1; d.itype = 5; end      // bgeu
            32'h0011_2623: begin d.mvalid = 1; d.mwen = 1; d.mwmask = 8'h0F; d.src2 = 1; d.itype = 1; end // sw
            32'h0010_8023: begin d.mvalid = 1; d.mwen = 1; d.mwmask = 8'h01; d.src2 = 1; d.itype = 1; end // sb
            32'h0010_9023: begin d.mvalid = 1; d.mwen = 1; d.mwmask = 8'h03; d.src2 = 1; d.itype = 1; end // sh
            32'h0041_4083: begin d.mvalid = 1; d.mrtype = 3; d.src2 = 1; d.rd = 1; end        // lbu
            32'h0010_9083: begin d.mvalid = 1; d.mrtype = 1; d.src2 = 1; d.rd = 1; end        // lh
            32'h4020_81B3: begin d.aluop = 1; d.itype = 2; d.rd = 0; end                      // sub
            32'h0020_B2B3: begin d.aluop = 1; d.cmpt = 4; d.itype = 2; d.rd = 3; end          // sltu
            32'h4030_D093: begin d.aluop = 7; d.src2 = 1; d.rd = 0; end                       // srai
            32'h1234_50B7: begin d.src1 = 2; d.src2 = 1; d.itype = 3; d.rd = 0; end           // lui
            32'h0000_0097: begin d.src1 = 1; d.src2 = 1; d.itype = 3; d.rd = 0; end           // auipc
            32'h0080_00EF: begin d.jump = 1; d.itype = 4; d.rd = 2; end                       // jal
            32'h0000_8067: begin d.jump = 1; d.jalr = 1; d.rd = 2; end                        // jalr
            32'h3052_9073: begin d.wcsr = 1; d.src2 = 3; d.rd = 4; end                        // csrrw
            32'h3000_2073: begin d.wcsr = 1; d.src2 = 2; d.aluop = 3; d.rd = 4; end           // csrrs
            32'h0000_0073: d.ecall = 1;
            32'h3020_0073: d.mret  = 1;
            32'h0010_0073: d.stop  = 1;
            default: ;  // csrrc, all-ones, etc.: illegal, defaults
        endcase
        return d;
    endfunction

    task automatic drive(input logic sv, input logic [31:0] i, input logic mr);
        @(negedge clk);
        s_valid = sv;
        instF   = i;
        pcF     = pc_n;
        snpcF   = pc_n + 32'd4;
        m_ready = mr;
        #1;
        if (sv && s_ready) begin
            q.push_back('{i, pc_n, pc_n + 32'd4, exp_dec(i)});
            pc_n = pc_n + 32'd4;
        end
    endtask

    // Monitor: a transfer happens on the coming edge when m_valid & m_ready.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (rst && m_valid && m_ready) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mon_underflow: got inst %h expected none", instD);
                end else begin
                    it = q.pop_front();
                    chk("instD", instD, it.inst);
                    chk("pcD",   pcD,   it.pc);
                    chk("snpcD", snpcD, it.snpc);
                    chk($sformatf("dec_%h", it.inst), act, it.dec);
                end
            end
        end
    end

    logic [31:0] stream [20] = '{
        32'h0050_0093, 32'hFE20_9EE3, 32'h0011_2623, 32'h0041_4083, 32'h3052_9073,
        32'h0000_0073, 32'h3020_0073, 32'h0010_0073, 32'h4020_81B3, 32'h0020_B2B3,
        32'h4030_D093, 32'h1234_50B7, 32'h0000_0097, 32'h0080_00EF, 32'h0000_8067,
        32'h3000_2073, 32'h3000_3073, 32'hFFFF_FFFF, 32'h0010_8023, 32'h0010_9023
    };

    initial begin
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        instF = '0; pcF = '0; snpcF = '0;
        #12;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_instD",   instD,   32'h0);
        chk("rst_pcD",     pcD,     32'h0);
        chk("rst_snpcD",   snpcD,   32'h0);
        chk("rst_dec",     act,     dflt());
        chk("rst_s_ready", s_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back streaming with the consumer always ready.
        foreach (stream[k]) drive(1'b1, stream[k], 1'b1);
        drive(1'b1, 32'h0020_F463, 1'b1);
        drive(1'b1, 32'h0010_9083, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        chk("drained_m_valid", m_valid, 1'b0);

        // Backpressure: A loads, B is refused while stalled, then load+drain together.
        drive(1'b1, 32'h0050_0093, 1'b0);
        drive(1'b1, 32'h4020_81B3, 1'b0);
        chk("stall_s_ready", s_ready, 1'b0);
        chk("stall_instD",   instD,   32'h0050_0093);
        drive(1'b1, 32'h4020_81B3, 1'b0);
        chk("hold_instD",    instD,   32'h0050_0093);
        chk("hold_m_valid",  m_valid, 1'b1);
        drive(1'b1, 32'h4020_81B3, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        chk("ld_drain_m_valid", m_valid, 1'b1);
        chk("ld_drain_instD",   instD,   32'h4020_81B3);
        drive(1'b0, 32'h0, 1'b1);
        chk("idle_m_valid", m_valid, 1'b0);

        // Asynchronous reset in the middle of a held transaction.
        drive(1'b1, 32'h0010_0073, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        chk("pre_rst_m_valid", m_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_m_valid", m_valid, 1'b0);
        chk("async_rst_instD",   instD,   32'h0);
        chk("async_rst_pcD",     pcD,     32'h0);
        q.delete();
        drive(1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        drive(1'b1, 32'h0000_0073, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/idu.md
Name: idu

Overview:
- Decode stage of the 5-stage RV32I core: fetch→decode pipeline register with valid/ready handshake plus a combinational instruction decoder.
- Captures instruction/PC from fetch, holds them for the execute stage, and produces the control signals execute/memory/writeback consume.
- Supports RV32I, csrrw/csrrs, ecall, mret, ebreak.

Parameters:
- XLEN, 32, data/address width of instruction, PC and snpc.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous, active-low reset.
- instF, pcF, snpcF in XLEN: fetched instruction, its PC, and PC+4.
- s_valid in 1 / s_ready out 1: upstream handshake.
- m_valid out 1 / m_ready in 1: downstream handshake.
- instD, pcD, snpcD out XLEN: registered copies.
- mvalidD out 1: memory access. mwenD out 1: store. mwmaskD out 8: store byte mask. mrtypeD out 3: load type.
- cmp_typeD out 3, branchD out 1, jumpD out 1, jalrD out 1.
- ALU_opD out 3, ALUsrc1D out 2, ALUsrc2D out 2, rdregsrcD out 3, inst_type out 3.
- ecallD, mretD, write_csr, stop_sim out 1.

Behaviour:
- Async reset (rst=0): m_valid=0, instD=pcD=snpcD=0. Decode of 0 is illegal, so it is side-effect free.
- s_ready = ~m_valid | m_ready (combinational).
- Rising clk:
  - s_valid&s_ready: load instF/pcF/snpcF and set m_valid=1.
  - Otherwise, m_ready: m_valid=0.
  - Otherwise hold.
  - Load and drain in the same cycle leaves m_valid=1. Latency is 1 cycle.
- Decoder is purely combinational from instD (opcode[6:0], funct3[14:12], funct7[31:25], funct12[31:20]). Outputs are valid regardless of m_valid.
- Encodings:
  - ALU_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
  - ALUsrc1: 0 rs1, 1 pc, 2 zero. ALUsrc2: 0 rs2, 1 imm, 2 csr, 3 zero.
  - rdregsrc: 0 ALU, 1 mem, 2 snpc, 3 cmp, 4 csr, 5 no write.
  - inst_type: 0 I, 1 S, 2 R, 3 U, 4 J, 5 B.
  - cmp_type: 0 eq, 1 ne, 2 lt, 3 ge, 4 ltu, 5 geu.
  - mrtype: 0 b, 1 h, 2 w, 3 bu, 4 hu.
- Default for every output is 0, except rdregsrc=5.
- LUI: src1=zero, src2=imm, ADD, U, rd=ALU.
- AUIPC: src1=pc, src2=imm, ADD, U, rd=ALU.
- JAL: jump=1, J, rd=snpc.
- JALR: jump=jalr=1, I, rd=snpc.
- Branch: branch=1, SUB, rs1/rs2, B, cmp_type from funct3 (000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu), rd=none.
- Loads: mvalid=1, ADD rs1+imm, I, rd=mem, mrtype from funct3 (000→0, 001→1, 010→2, 100→3, 101→4).
- Stores: mvalid=mwen=1, ADD rs1+imm, S, rd=none; mwmask sb=0x01, sh=0x03, sw=0x0F.
- OP-IMM/OP (I/R):
  - Operations: add/addi ADD, sub SUB, and AND, or OR, xor XOR, sll SLL, srl SRL, sra/srai SRA (funct7=0100000).
  - slt/slti and sltu/sltiu: SUB with cmp_type 2/4, rd=cmp.
- csrrw: write_csr=1, src1=rs1, src2=zero, ADD, rd=csr.
- csrrs: write_csr=1, src1=rs1, src2=csr, OR, rd=csr.
- ecall (0x00000073): ecall=1, rd=none.
- mret (0x30200073): mret=1, rd=none.
- ebreak (0x00100073): stop_sim=1, rd=none.
- Any other encoding, including other csr funct3 values, is illegal: all defaults, no trap, stop_sim=0.

Test Plan:
- Reset then release; s_valid=1, instF=0x00500093, pcF=0x80000000 → next cycle m_valid=1, instD=0x00500093, pcD=0x80000000; decode ALU_op=0, ALUsrc1=0, ALUsrc2=1, rdregsrc=0, inst_type=0.
- Hold m_ready=0 with m_valid=1 → s_ready=0; new instF is ignored and instD holds. Raise m_ready with s_valid=1 → new word loads and m_valid stays 1.
- instD=0xFE209EE3 (bne) → branch=1, cmp_type=1, ALU_op=1, inst_type=5, rdregsrc=5.
- instD=0x00112623 (sw) → mvalid=1, mwen=1, mwmask=0x0F, inst_type=1. instD=0x00414083 (lbu) → mrtype=3, rdregsrc=1.
- instD=0x30529073 (csrrw mtvec) → write_csr=1, ALUsrc2=3, rdregsrc=4. instD=0x00000073 → ecall=1. instD=0x30200073 → mret=1.
- instD=0x00100073 → stop_sim=1. Assert rst low mid-stream → m_valid=0 and instD=0 immediately.
